// File: rtl/sr_pulse_arbiter.sv
// Round-robin arbiter that turns set/clear requests into timed, mutually exclusive S/R pulses
// on an SR latch bank, then checks the latch's Q feedback and reports done/err.
module sr_pulse_arbiter #(
    parameter int NREQ      = 4,
    parameter int NBITS     = 8,
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 1,
    parameter int IDXW      = $clog2(NBITS),
    localparam int RIDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_set,
    input  logic [NREQ*IDXW-1:0] req_idx,
    output logic [NREQ-1:0]      req_ready,
    output logic [NBITS-1:0]     S,
    output logic [NBITS-1:0]     R,
    input  logic [NBITS-1:0]     Q_sense,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [RIDW-1:0]      done_req
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PULSE  = 2'd1;
    localparam logic [1:0] ST_VERIFY = 2'd2;
    localparam logic [1:0] ST_GAP    = 2'd3;

    localparam int CMAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RIDW-1:0]  id_q, id_d;
    logic [RIDW-1:0]  ptr_q, ptr_d;
    logic             op_q, op_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [NBITS-1:0] s_q, s_d, r_q, r_d;
    logic             done_q, done_d, err_q, err_d;
    logic [RIDW-1:0]  done_req_q, done_req_d;

    logic [NREQ-1:0]  grant;
    logic [RIDW-1:0]  win;
    logic             found;
    logic [IDXW-1:0]  win_idx;
    logic [NBITS-1:0] win_mask, cur_mask;

    // One-hot decode of a latch index; out-of-range indices decode to all zeros.
    function automatic logic [NBITS-1:0] idx_dec(input logic [IDXW-1:0] i);
        logic [NBITS-1:0] m;
        m = '0;
        for (int b = 0; b < NBITS; b++) begin
            if (i == IDXW'(b)) m[b] = 1'b1;
        end
        return m;
    endfunction

    always_comb begin
        grant = '0;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            automatic int j = (int'(ptr_q) + k) % NREQ;
            if (!found && req_valid[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                win      = RIDW'(j);
            end
        end
    end

    assign req_ready = (state_q == ST_IDLE && !rst) ? grant : '0;
    assign win_idx   = req_idx[int'(win)*IDXW +: IDXW];
    assign win_mask  = idx_dec(win_idx);
    assign cur_mask  = idx_dec(idx_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        id_d       = id_q;
        ptr_d      = ptr_q;
        op_d       = op_q;
        idx_d      = idx_q;
        s_d        = '0;
        r_d        = '0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        done_req_d = done_req_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_PULSE;
                    cnt_d   = CW'(PULSE_CYC - 1);
                    id_d    = win;
                    op_d    = req_set[win];
                    idx_d   = win_idx;
                    ptr_d   = (win == RIDW'(NREQ - 1)) ? '0 : win + 1'b1;
                    s_d     = req_set[win] ? win_mask : '0;
                    r_d     = req_set[win] ? '0 : win_mask;
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_VERIFY;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    s_d   = s_q;
                    r_d   = r_q;
                end
            end
            ST_VERIFY: begin
                state_d    = ST_GAP;
                cnt_d      = CW'(GAP_CYC - 1);
                done_d     = 1'b1;
                done_req_d = id_q;
                // An empty mask means the index was out of range: always an error.
                err_d      = (cur_mask == '0) || ((|(Q_sense & cur_mask)) != op_q);
            end
            ST_GAP: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            id_q       <= '0;
            ptr_q      <= '0;
            op_q       <= 1'b0;
            idx_q      <= '0;
            s_q        <= '0;
            r_q        <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            done_req_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            id_q       <= id_d;
            ptr_q      <= ptr_d;
            op_q       <= op_d;
            idx_q      <= idx_d;
            s_q        <= s_d;
            r_q        <= r_d;
            done_q     <= done_d;
            err_q      <= err_d;
            done_req_q <= done_req_d;
        end
    end

    assign S        = s_q;
    assign R        = r_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign done_req = done_req_q;

endmodule

// File: tb/tb_sr_pulse_arbiter.sv
// Scoreboard bench for sr_pulse_arbiter: a service-timeline reference model checks grants and
// S/R pulses every cycle, and a monitor pops expected completions whenever done is seen.
`timescale 1ns/1ps
module tb_sr_pulse_arbiter;

    localparam int NREQ  = 4;
    localparam int NBITS = 6;
    localparam int P     = 2;
    localparam int G     = 1;
    localparam int IDXW  = 3;
    localparam int RIDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_set = '0;
    logic [NREQ*IDXW-1:0] req_idx = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NBITS-1:0]     S, R, Q_sense;
    logic                 busy, done, err;
    logic [RIDW-1:0]      done_req;

    sr_pulse_arbiter #(
        .NREQ(NREQ), .NBITS(NBITS), .PULSE_CYC(P), .GAP_CYC(G)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_set(req_set), .req_idx(req_idx),
        .req_ready(req_ready), .S(S), .R(R), .Q_sense(Q_sense), .busy(busy), .done(done),
        .err(err), .done_req(done_req)
    );

    always #5 clk = ~clk;

    // Physical latch bank with optional stuck-at faults.
    logic [NBITS-1:0] bank = '0;
    logic [NBITS-1:0] stuck0 = '0, stuck1 = '0;
    always @(S or R) bank = (bank | S) & ~R;
    assign Q_sense = (bank | stuck1) & ~stuck0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit model_on = 1'b0;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    typedef struct { int id; bit err; } exp_t;
    exp_t sb[$];

    // Reference model: ph = cycles since accept (-1 when idle).
    int ph = -1;
    int m_ptr = 0;
    int m_idx, m_id, w;
    bit m_op, m_in, rst_prev;
    logic [NREQ-1:0]  e_rdy;
    logic [NBITS-1:0] e_s, e_r;
    exp_t e;

    always @(negedge clk) begin
        if (model_on) begin
            w = -1;
            if (ph < 0 && !rst) begin
                for (int k = 0; k < NREQ; k++) begin
                    automatic int j = (m_ptr + k) % NREQ;
                    if (w < 0 && req_valid[j]) w = j;
                end
            end
            e_rdy = '0;
            if (w >= 0) e_rdy[w] = 1'b1;
            e_s = '0;
            e_r = '0;
            if (ph >= 1 && ph <= P && m_in) begin
                if (m_op) e_s[m_idx] = 1'b1;
                else      e_r[m_idx] = 1'b1;
            end
            chk("req_ready", 32'(req_ready), 32'(e_rdy));
            chk("busy", 32'(busy), 32'(ph > 0));
            chk("S", 32'(S), 32'(e_s));
            chk("R", 32'(R), 32'(e_r));
            chk("done", 32'(done), 32'(ph == P + 2));
            if (ph != P + 2) chk("err_outside_done", 32'(err), 32'(0));
            if (rst_prev) chk("done_req_reset", 32'(done_req), 32'(0));
            chk("s_and_r_zero", 32'(|(S & R)), 32'(0));
            chk("onehot0_s_or_r", 32'($onehot0(S | R)), 32'(1));
            #1;
            rst_prev = rst;
            if (rst) begin
                ph = -1;
                m_ptr = 0;
                sb.delete();
            end else if (ph > 0) begin
                ph++;
                if (ph > P + G + 1) ph = -1;
            end else if (w >= 0) begin
                m_id  = w;
                m_op  = req_set[w];
                m_idx = int'(req_idx[w*IDXW +: IDXW]);
                m_in  = (m_idx < NBITS);
                m_ptr = (w + 1) % NREQ;
                ph    = 1;
                e.id  = w;
                if (!m_in) e.err = 1'b1;
                else if (stuck1[m_idx]) e.err = (m_op != 1'b1);
                else if (stuck0[m_idx]) e.err = (m_op != 1'b0);
                else e.err = 1'b0;
                sb.push_back(e);
            end
        end
    end

    // Completion monitor.
    exp_t got;
    always @(negedge clk) begin
        if (model_on && done) begin
            chk("sb_nonempty_on_done", 32'(sb.size() > 0), 32'(1));
            if (sb.size() > 0) begin
                got = sb.pop_front();
                chk("done_req", 32'(done_req), 32'(got.id));
                chk("err", 32'(err), 32'(got.err));
            end
        end
    end

    // Stimulus: pending requests per requester, applied shortly after each rising edge.
    int mode = 0;  // 0 directed, 1 all held valid, 2 random
    logic [NREQ-1:0] pv = '0, ps = '0, acc;
    logic [IDXW-1:0] pi [NREQ];
    int glog[$];
    int gcyc[$];

    always @(negedge clk) begin
        acc = req_valid & req_ready;
        for (int k = 0; k < NREQ; k++) begin
            if (acc[k]) begin
                glog.push_back(k);
                gcyc.push_back(cyc);
                pv[k] = 1'b0;
            end
            if (mode == 1 && !pv[k]) begin
                pv[k] = 1'b1;
                ps[k] = 1'($urandom_range(0, 1));
                pi[k] = IDXW'($urandom_range(0, NBITS - 1));
            end else if (mode == 2 && !pv[k]) begin
                pv[k] = ($urandom_range(0, 3) == 0);
                ps[k] = 1'($urandom_range(0, 1));
                pi[k] = IDXW'($urandom_range(0, 7));
            end
        end
    end

    always begin
        @(posedge clk);
        #2;
        req_valid = pv;
        req_set   = ps;
        for (int k = 0; k < NREQ; k++) req_idx[k*IDXW +: IDXW] = pi[k];
    end

    task automatic set_req(input int k, input bit s, input int i);
        pv[k] = 1'b1;
        ps[k] = s;
        pi[k] = IDXW'(i);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic wait_quiet(input int bound);
        bit q = 1'b0;
        for (int i = 0; i < bound && !q; i++) begin
            @(negedge clk); #2;
            q = (pv == '0) && (ph < 0) && (req_valid == '0);
        end
        chk("quiet_within_bound", 32'(q), 32'(1));
    endtask

    int rr_exp [5] = '{0, 1, 2, 3, 0};

    initial begin
        for (int k = 0; k < NREQ; k++) pi[k] = '0;
        @(posedge clk); #1 model_on = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single set, then clear against a latch stuck at 1.
        @(posedge clk); #1 set_req(0, 1'b1, 3);
        wait_quiet(50);
        stuck1 = 6'h20;
        @(posedge clk); #1 set_req(1, 1'b0, 5);
        wait_quiet(50);
        stuck1 = '0;

        // Round-robin with all requesters held valid.
        pulse_reset();
        glog.delete(); gcyc.delete();
        mode = 1;
        repeat (25) @(posedge clk);
        mode = 0;
        wait_quiet(100);
        chk("rr_grant_count", 32'(glog.size() >= 5), 32'(1));
        if (glog.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk("rr_order", 32'(glog[i]), 32'(rr_exp[i]));
            for (int i = 0; i < 4; i++) chk("rr_spacing", 32'(gcyc[i+1] - gcyc[i]), 32'(5));
        end

        // Conflicting set/clear of latch 0.
        pulse_reset();
        glog.delete(); gcyc.delete();
        @(posedge clk); #1 set_req(2, 1'b1, 0); set_req(3, 1'b0, 0);
        wait_quiet(50);
        chk("conflict_first", 32'(glog.size() > 0 ? glog[0] : -1), 32'(2));
        chk("conflict_final_q0", 32'(Q_sense[0]), 32'(0));

        // Reset in the second pulse cycle; pointer must return to requester 0.
        @(posedge clk); #1 set_req(0, 1'b1, 1);
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        glog.delete(); gcyc.delete();
        @(posedge clk); #1 set_req(1, 1'b1, 2); set_req(0, 1'b0, 1);
        wait_quiet(50);
        chk("grant_after_reset", 32'(glog.size() > 0 ? glog[0] : -1), 32'(0));

        // Out-of-range indices still sequenced, reported as errors.
        @(posedge clk); #1 set_req(2, 1'b1, 7); set_req(3, 1'b0, 6);
        wait_quiet(50);

        // Random traffic with a fixed random fault pattern.
        stuck0 = NBITS'($urandom) & NBITS'($urandom);
        stuck1 = NBITS'($urandom) & NBITS'($urandom) & ~stuck0;
        mode = 2;
        repeat (10000) @(posedge clk);
        mode = 0;
        wait_quiet(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
